iorq_bus_ctrl: RTL
==================

// Module: iorq_bus_ctrl
// PURPOSE
//  Sequences Z8S180 external I/O cycles onto up to 2^NSLOT_LOG2 internal peripherals.
//  - Detects the start of an I/O read or write cycle and decodes the address window.
//  - Issues a one-shot request to the selected slot and holds the CPU with wait_req until ack.
//  - Returns read data to the CPU data bus and recovers from an unresponsive slot by timeout.
//  - Sits between the synchronized CPU bus pins and the FPGA peripheral register blocks.
// PARAMETERS
//  ADDR_BASE   8'h40  first I/O address of window; aligned to window size
//  NSLOT_LOG2  2      log2 number of peripheral slots
//  REG_LOG2    2      log2 registers per slot; window = 2^(NSLOT_LOG2+REG_LOG2) ports
//  TIMEOUT     16     phi cycles in WAIT_ACK before forced completion (>=2)
// PORTS
//  phi          in   1            system clock (CPU PHI)
//  reset        in   1            synchronous, active-high
//  iorq         in   1            CPU IORQ, positive logic
//  rd           in   1            CPU RD, positive logic
//  wr           in   1            CPU WR, positive logic
//  m1           in   1            CPU M1, positive logic; iorq&m1 = INTA, never decoded
//  addr         in   8            CPU A[7:0]
//  dbus_in      in   8            CPU data bus, write data
//  dbus_out     out  8            read data to CPU
//  dbus_oe      out  1            drive dbus_out onto CPU bus
//  wait_req     out  1            hold CPU (positive logic; inverted at pin)
//  p_req        out  2^NSLOT_LOG2 one-hot, one-cycle request per slot
//  p_we         out  1            1=write, 0=read; valid with p_req
//  p_addr       out  REG_LOG2     register index within slot
//  p_wdata      out  8            write data; valid with p_req
//  p_rdata      in   8*2^NSLOT_LOG2 slot read data, slot s at [8s+7:8s]
//  p_ack        in   2^NSLOT_LOG2 slot completion, one bit per slot
//  timeout_err  out  1            one-cycle pulse on forced completion
// BEHAVIOUR
//  Reset: state IDLE; dbus_out=8'h00; all other outputs 0; timeout counter 0.
//  Start: cyc = iorq & ~m1 & (rd|wr); start = cyc & ~cyc_q (cyc_q = cyc registered).
//   - A write starts on WR assertion, not IORQ.
//  On start in IDLE: latch addr, dbus_in, we=wr; hit = addr within window.
//   - hit & exactly one of rd/wr -> REQ.
//   - miss, or rd&wr both high -> HOLD, no p_req, no wait, no oe.
//  REQ (1 cycle): p_req[slot]=1, wait_req=1; ack may arrive this cycle.
//   - ack -> DONE; else -> WAIT_ACK.
//  WAIT_ACK: wait_req=1, p_req=0; counter increments each cycle.
//   - ack -> DONE.
//   - counter==TIMEOUT-1 -> DONE with timeout_err=1 and read data forced to 8'hFF.
//  Ack rules: only p_ack[slot] of the latched slot counts; other ack bits are ignored.
//   - On accepted read ack, capture the p_rdata slice into dbus_out in the same edge.
//  DONE: wait_req=0 (first cycle after ack); dbus_oe = ~we & rd -> HOLD.
//  HOLD: dbus_oe stays = ~we & rd & hit; -> IDLE when iorq=0 (dbus_oe=0 that edge).
//  Abort: iorq=0 in REQ/WAIT_ACK -> IDLE next edge.
//   - wait_req, dbus_oe, counter cleared; a late ack is ignored.
//  New start is accepted only in IDLE; a back-to-back cycle needs iorq low for >=1 phi.
//  wait_req latency: high on the edge after start; low on the edge after ack.
//  Reset mid-cycle returns to IDLE immediately; outputs take reset values.
// STRUCTURE
//  iorq_pkg: state encoding (IDLE, REQ, WAIT_ACK, DONE, HOLD); window-mask helper function.
//  Sub-module iorq_start_detect: registers cyc, emits start and is_wr; reusable by other I/O blocks.
//  Main FSM, slot decode, timeout counter and read-data capture stay in iorq_bus_ctrl.
// TESTING
//  1 Write 8'hA5 to 8'h45, slot1 acks 2 cycles after p_req:
//    p_req=4'b0010 one cycle, p_addr=1, p_wdata=A5, p_we=1;
//    wait_req high 3 cycles; dbus_oe stays 0.
//  2 Read 8'h4E, slot3 acks in REQ with p_rdata[31:24]=8'h3C:
//    wait_req high 1 cycle; dbus_out=3C; dbus_oe high until iorq drops.
//  3 Read 8'h4F, no ack: wait_req high exactly TIMEOUT+1 cycles;
//    timeout_err one pulse; dbus_out=FF.
//  4 Read 8'h20 (miss), and INTA (iorq&m1): no p_req, wait_req=0, dbus_oe=0 throughout.
//  5 iorq drops in WAIT_ACK, then slot acks: returns to IDLE, ack ignored.
//    Next write to 8'h40 proceeds normally.
//  6 Assert reset during WAIT_ACK: all outputs 0 next edge; the next cycle works normally.
//    Also: slot2 ack during slot0 cycle is ignored.

Source files
------------

// File: rtl/iorq_pkg.sv
// iorq_pkg: shared state encoding, default parameters and address-window helper for the I/O bus controller
package iorq_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, DONE, HOLD} state_t;

    localparam logic [7:0] DEF_ADDR_BASE = 8'h40;
    localparam int DEF_TIMEOUT = 16;

    // Mask that clears the low 'bits' address bits, leaving the window-select bits
    function automatic logic [7:0] win_mask(input int bits);
        return 8'hFF << bits;
    endfunction

endpackage

// File: rtl/iorq_start_detect.sv
// iorq_start_detect: one-shot start of a qualified CPU I/O read/write cycle (INTA excluded)
module iorq_start_detect (
    input  logic phi,
    input  logic reset,
    input  logic iorq,
    input  logic m1,
    input  logic rd,
    input  logic wr,
    output logic start,
    output logic is_wr
);

    logic cyc;
    logic cyc_q;

    assign cyc = iorq & ~m1 & (rd | wr);

    // Remember last cycle's qualifier so a write is caught when WR rises, not IORQ
    always_ff @(posedge phi) begin
        cyc_q <= reset ? 1'b0 : cyc;
    end

    assign start = cyc & ~cyc_q;
    assign is_wr = wr;

endmodule

// File: rtl/iorq_bus_ctrl.sv
// iorq_bus_ctrl: sequences Z8S180 I/O cycles onto peripheral slots with wait, read-back and timeout
module iorq_bus_ctrl
    import iorq_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE  = DEF_ADDR_BASE,
    parameter int         NSLOT_LOG2 = 2,
    parameter int         REG_LOG2   = 2,
    parameter int         TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                            phi,
    input  logic                            reset,
    input  logic                            iorq,
    input  logic                            rd,
    input  logic                            wr,
    input  logic                            m1,
    input  logic [7:0]                      addr,
    input  logic [7:0]                      dbus_in,
    output logic [7:0]                      dbus_out,
    output logic                            dbus_oe,
    output logic                            wait_req,
    output logic [(1<<NSLOT_LOG2)-1:0]      p_req,
    output logic                            p_we,
    output logic [REG_LOG2-1:0]             p_addr,
    output logic [7:0]                      p_wdata,
    input  logic [8*(1<<NSLOT_LOG2)-1:0]    p_rdata,
    input  logic [(1<<NSLOT_LOG2)-1:0]      p_ack,
    output logic                            timeout_err
);

    localparam int NS = 1 << NSLOT_LOG2;
    localparam int CW = $clog2(TIMEOUT);

    state_t                state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  hit_q, hit_d;
    logic                  terr_q, terr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  start, is_wr;
    logic [NSLOT_LOG2-1:0] slot;
    logic                  ack;
    logic [7:0]            slot_rdata;

    iorq_start_detect u_start (
        .phi   (phi),
        .reset (reset),
        .iorq  (iorq),
        .m1    (m1),
        .rd    (rd),
        .wr    (wr),
        .start (start),
        .is_wr (is_wr)
    );

    assign slot       = addr_q[REG_LOG2 +: NSLOT_LOG2];
    assign ack        = p_ack[slot];
    assign slot_rdata = p_rdata[{slot, 3'b000} +: 8];

    // Next-state logic: latch the cycle, track ack/timeout, capture read data, abort on IORQ loss
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        hit_d   = hit_q;
        terr_d  = 1'b0;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = addr;
                wdata_d = dbus_in;
                we_d    = is_wr;
                hit_d   = (addr & win_mask(NSLOT_LOG2 + REG_LOG2)) == ADDR_BASE;
                state_d = (hit_d && (rd ^ wr)) ? REQ : HOLD;
            end
            REQ: if (!iorq) begin
                state_d = IDLE;
            end else if (ack) begin
                state_d = DONE;
                rdata_d = we_q ? rdata_q : slot_rdata;
            end else begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (!iorq) begin
                state_d = IDLE;
            end else if (ack) begin
                state_d = DONE;
                rdata_d = we_q ? rdata_q : slot_rdata;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = DONE;
                terr_d  = 1'b1;
                rdata_d = we_q ? rdata_q : 8'hFF;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE:    state_d = HOLD;
            HOLD:    state_d = iorq ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge phi) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wait_req    = (state_q == REQ) || (state_q == WAIT_ACK);
    assign p_req       = (state_q == REQ) ? (NS'(1) << slot) : '0;
    assign p_we        = we_q;
    assign p_addr      = addr_q[REG_LOG2-1:0];
    assign p_wdata     = wdata_q;
    assign dbus_out    = rdata_q;
    assign dbus_oe     = ((state_q == DONE) || (state_q == HOLD)) && !we_q && rd && hit_q;
    assign timeout_err = terr_q;

endmodule
